aes_job_arbiter: RTL and testbench

AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

---
 rtl/aes_job_arbiter_if.sv | 36 +++
 rtl/aes_job_arbiter.sv | 96 +++++++++
 tb/tb_aes_job_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_job_arbiter_if.sv
// aes_job_arbiter_if: requester, core and response signals of the AES job arbiter
interface aes_job_arbiter_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_key;
    logic [127:0] req0_data;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_key;
    logic [127:0] req1_data;
    logic         core_start;
    logic [127:0] core_key;
    logic [127:0] core_data;
    logic         core_done;
    logic [127:0] core_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         busy;

    modport slave (
        input  req0_valid, req0_key, req0_data, req1_valid, req1_key, req1_data,
        input  core_done, core_result, rsp_ready,
        output req0_ready, req1_ready, core_start, core_key, core_data,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_key, req0_data, req1_valid, req1_key, req1_data,
        output core_done, core_result, rsp_ready,
        input  req0_ready, req1_ready, core_start, core_key, core_data,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin arbiter feeding one shared AES core, with a watchdog
module aes_job_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    aes_job_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t       state, state_n;
    logic         last, last_n;
    logic         id_q, id_n;
    logic         err_q, err_n;
    logic [127:0] key_q, key_n;
    logic [127:0] data_q, data_n;
    logic [127:0] res_q, res_n;
    logic [15:0]  cnt, cnt_n, cnt_inc;
    logic         g0, g1;

    assign g0      = bus.req0_valid && (!bus.req1_valid || last);
    assign g1      = bus.req1_valid && (!bus.req0_valid || !last);
    assign cnt_inc = cnt + 16'd1;

    assign bus.req0_ready = (state == IDLE) && g0;
    assign bus.req1_ready = (state == IDLE) && g1;
    assign bus.core_start = state == LAUNCH;
    assign bus.core_key   = key_q;
    assign bus.core_data  = data_q;
    assign bus.rsp_valid  = state == RESP;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = res_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = state != IDLE;

    // next-state: accept the round-robin winner, launch, wait for done or watchdog, hold response
    always_comb begin
        state_n = state;
        last_n  = last;
        id_n    = id_q;
        err_n   = err_q;
        key_n   = key_q;
        data_n  = data_q;
        res_n   = res_q;
        cnt_n   = cnt;
        case (state)
            IDLE: if (g0 || g1) begin
                state_n = LAUNCH;
                last_n  = g1;
                id_n    = g1;
                key_n   = g1 ? bus.req1_key : bus.req0_key;
                data_n  = g1 ? bus.req1_data : bus.req0_data;
            end
            LAUNCH: begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: if (bus.core_done) begin
                state_n = RESP;
                res_n   = bus.core_result;
                err_n   = 1'b0;
            end else if (cnt_inc == 16'(TIMEOUT)) begin
                state_n = RESP;
                res_n   = '0;
                err_n   = 1'b1;
            end else begin
                cnt_n = cnt_inc;
            end
            RESP: state_n = bus.rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // state and operand registers; reset abandons any job in flight without a response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            id_q   <= 1'b0;
            err_q  <= 1'b0;
            key_q  <= '0;
            data_q <= '0;
            res_q  <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            last   <= last_n;
            id_q   <= id_n;
            err_q  <= err_n;
            key_q  <= key_n;
            data_q <= data_n;
            res_q  <= res_n;
            cnt    <= cnt_n;
        end
    end
endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb_aes_job_arbiter: directed self-checking bench for the AES job arbiter
module tb_aes_job_arbiter;
    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DAT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RES  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1   = 128'hb1b1b1b1b1b1b1b1b1b1b1b1b1b1b1b1;
    localparam logic [127:0] R2   = 128'hdeadbeef00112233445566778899aabb;
    localparam logic [127:0] R3   = 128'h33333333333333333333333333333333;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   lat = 20;
    int   ccnt = 0;
    int   starts = 0;
    logic force_done = 1'b0;

    always #5 clk = ~clk;

    aes_job_arbiter_if bi();
    aes_job_arbiter_if ti();

    aes_job_arbiter u_dut (.clk(clk), .rst(rst), .bus(bi));
    aes_job_arbiter #(.TIMEOUT(8)) u_dut8 (.clk(clk), .rst(rst), .bus(ti));

    // core model for the default instance: done pulses lat cycles after core_start
    always @(negedge clk) begin
        bi.core_done = force_done;
        if (!rst) ccnt = 0;
        else begin
            if (ccnt > 0) begin
                ccnt--;
                if (ccnt == 0) bi.core_done = 1'b1;
            end
            if (bi.core_start) begin
                starts++;
                ccnt = lat;
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset;
        tick(2);
        tests++; if (bi.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bi.busy); end
        tests++; if (bi.core_start !== 1'b0) begin fails++; $display("FAIL reset_core_start got %b exp 0", bi.core_start); end
        tests++; if (bi.rsp_valid !== 1'b0 || bi.rsp_err !== 1'b0 || bi.rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp got v%b e%b id%b exp 000", bi.rsp_valid, bi.rsp_err, bi.rsp_id); end
        tests++; if (bi.rsp_data !== '0) begin fails++; $display("FAIL reset_rsp_data got %h exp 0", bi.rsp_data); end
        tests++; if (bi.core_key !== '0 || bi.core_data !== '0) begin fails++; $display("FAIL reset_core_ops got %h %h exp 0", bi.core_key, bi.core_data); end
        tests++; if (ti.busy !== 1'b0) begin fails++; $display("FAIL reset_busy8 got %b exp 0", ti.busy); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_round_robin;
        logic exp;
        int   n;
        lat = 3;
        bi.req0_valid = 1'b1; bi.req0_key = KEY;
        bi.req1_valid = 1'b1; bi.req1_key = K1;
        #1;
        for (int j = 0; j < 4; j++) begin
            exp = j[0];
            n = 0;
            while (!(bi.req0_ready || bi.req1_ready) && n < 10) begin tick(); n++; end
            tests++; if (bi.req0_ready !== !exp || bi.req1_ready !== exp) begin fails++; $display("FAIL rr_grant job %0d got r0=%b r1=%b exp id %b", j, bi.req0_ready, bi.req1_ready, exp); end
            tick();
            tests++; if (bi.core_key !== (exp ? K1 : KEY)) begin fails++; $display("FAIL rr_key job %0d got %h exp %h", j, bi.core_key, exp ? K1 : KEY); end
            n = 0;
            while (!bi.rsp_valid && n < 20) begin tick(); n++; end
            tests++; if (bi.rsp_valid !== 1'b1 || bi.rsp_id !== exp || bi.rsp_data !== RES) begin fails++; $display("FAIL rr_rsp job %0d got v%b id%b %h exp id %b %h", j, bi.rsp_valid, bi.rsp_id, bi.rsp_data, exp, RES); end
            bi.rsp_ready = 1'b1;
            tick();
            bi.rsp_ready = 1'b0;
        end
        bi.req0_valid = 1'b0; bi.req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_single;
        int n, s0;
        lat = 20;
        bi.req0_valid = 1'b1; bi.req0_key = KEY; bi.req0_data = DAT;
        #1;
        tests++; if (bi.req0_ready !== 1'b1 || bi.req1_ready !== 1'b0) begin fails++; $display("FAIL single_ready got r0=%b r1=%b exp 1 0", bi.req0_ready, bi.req1_ready); end
        s0 = starts;
        tick();
        bi.req0_valid = 1'b0;
        tests++; if (bi.core_start !== 1'b1 || bi.busy !== 1'b1 || bi.req0_ready !== 1'b0) begin fails++; $display("FAIL single_launch got start=%b busy=%b r0=%b exp 1 1 0", bi.core_start, bi.busy, bi.req0_ready); end
        tests++; if (bi.core_key !== KEY || bi.core_data !== DAT) begin fails++; $display("FAIL single_ops got %h %h exp %h %h", bi.core_key, bi.core_data, KEY, DAT); end
        n = 0;
        while (!bi.rsp_valid && n < 60) begin tick(); n++; end
        tests++; if (n !== 21) begin fails++; $display("FAIL single_latency got %0d exp 21", n); end
        tests++; if (bi.rsp_id !== 1'b0 || bi.rsp_err !== 1'b0 || bi.rsp_data !== RES) begin fails++; $display("FAIL single_rsp got id%b e%b %h exp 0 0 %h", bi.rsp_id, bi.rsp_err, bi.rsp_data, RES); end
        tests++; if (starts !== s0 + 1) begin fails++; $display("FAIL single_starts got %0d exp %0d", starts - s0, 1); end
        bi.rsp_ready = 1'b1;
        tick();
        bi.rsp_ready = 1'b0;
        tests++; if (bi.rsp_valid !== 1'b0 || bi.busy !== 1'b0) begin fails++; $display("FAIL single_done got v%b busy%b exp 0 0", bi.rsp_valid, bi.busy); end
    endtask

    task automatic test_hold;
        int n, s0;
        lat = 3;
        bi.req0_valid = 1'b1; bi.req0_key = KEY;
        tick();
        bi.req0_valid = 1'b0; bi.req1_valid = 1'b1;
        n = 0;
        while (!bi.rsp_valid && n < 20) begin tick(); n++; end
        s0 = starts;
        bi.req0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++; if (bi.rsp_valid !== 1'b1 || bi.rsp_id !== 1'b0 || bi.rsp_err !== 1'b0 || bi.rsp_data !== RES) begin fails++; $display("FAIL hold_rsp cycle %0d got v%b id%b e%b %h exp 1 0 0 %h", i, bi.rsp_valid, bi.rsp_id, bi.rsp_err, bi.rsp_data, RES); end
            tests++; if (bi.req0_ready !== 1'b0 || bi.req1_ready !== 1'b0 || starts !== s0) begin fails++; $display("FAIL hold_quiet cycle %0d got r0=%b r1=%b starts+%0d exp 0 0 +0", i, bi.req0_ready, bi.req1_ready, starts - s0); end
        end
        bi.req0_valid = 1'b0;
        bi.rsp_ready = 1'b1;
        tick();
        bi.rsp_ready = 1'b0;
        tests++; if (bi.req1_ready !== 1'b1) begin fails++; $display("FAIL hold_pending got r1=%b exp 1", bi.req1_ready); end
        bi.req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_timeout;
        int n;
        ti.req0_valid = 1'b1; ti.req0_key = KEY; ti.req0_data = DAT;
        tick();
        ti.req0_valid = 1'b0;
        tests++; if (ti.core_start !== 1'b1) begin fails++; $display("FAIL to_start got %b exp 1", ti.core_start); end
        tick();
        n = 0;
        while (!ti.rsp_valid && n < 20) begin tick(); n++; end
        tests++; if (n !== 8) begin fails++; $display("FAIL to_latency got %0d exp 8", n); end
        tests++; if (ti.rsp_err !== 1'b1 || ti.rsp_data !== '0 || ti.rsp_id !== 1'b0) begin fails++; $display("FAIL to_rsp got e%b id%b %h exp 1 0 0", ti.rsp_err, ti.rsp_id, ti.rsp_data); end
        ti.rsp_ready = 1'b1;
        tick();
        ti.rsp_ready = 1'b0;
    endtask

    task automatic test_coincide;
        ti.req1_valid = 1'b1; ti.req1_key = K1;
        tick();
        ti.req1_valid = 1'b0;
        tick(8);
        tests++; if (ti.rsp_valid !== 1'b0) begin fails++; $display("FAIL co_early got %b exp 0", ti.rsp_valid); end
        ti.core_done = 1'b1; ti.core_result = R2;
        tick();
        ti.core_done = 1'b0;
        tests++; if (ti.rsp_valid !== 1'b1 || ti.rsp_err !== 1'b0 || ti.rsp_id !== 1'b1 || ti.rsp_data !== R2) begin fails++; $display("FAIL co_rsp got v%b e%b id%b %h exp 1 0 1 %h", ti.rsp_valid, ti.rsp_err, ti.rsp_id, ti.rsp_data, R2); end
        ti.core_done = 1'b1; ti.core_result = R3;
        tick();
        ti.core_done = 1'b0;
        tests++; if (ti.rsp_valid !== 1'b1 || ti.rsp_data !== R2) begin fails++; $display("FAIL co_stray_done got v%b %h exp 1 %h", ti.rsp_valid, ti.rsp_data, R2); end
        ti.rsp_ready = 1'b1;
        tick();
        ti.rsp_ready = 1'b0;
        ti.core_done = 1'b1;
        tick();
        ti.core_done = 1'b0;
        tests++; if (ti.busy !== 1'b0 || ti.rsp_valid !== 1'b0) begin fails++; $display("FAIL co_idle_done got busy%b v%b exp 0 0", ti.busy, ti.rsp_valid); end
    endtask

    task automatic test_mid_reset;
        int n, s0;
        lat = 20;
        bi.req0_valid = 1'b1; bi.req0_key = KEY; bi.req0_data = DAT;
        tick();
        bi.req0_valid = 1'b0;
        tick(3);
        s0 = starts;
        rst = 1'b0;
        #1;
        tests++; if (bi.busy !== 1'b0 || bi.rsp_valid !== 1'b0 || bi.core_start !== 1'b0 || bi.rsp_err !== 1'b0) begin fails++; $display("FAIL mr_ctrl got busy%b v%b start%b e%b exp 0000", bi.busy, bi.rsp_valid, bi.core_start, bi.rsp_err); end
        tests++; if (bi.core_key !== '0 || bi.core_data !== '0 || bi.rsp_data !== '0) begin fails++; $display("FAIL mr_data got %h %h %h exp 0", bi.core_key, bi.core_data, bi.rsp_data); end
        tick();
        rst = 1'b1;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        n = 0;
        repeat (30) begin
            tick();
            if (bi.rsp_valid || bi.busy) n++;
        end
        tests++; if (n !== 0 || starts !== s0) begin fails++; $display("FAIL mr_stale got active %0d starts+%0d exp 0 +0", n, starts - s0); end
    endtask

    initial begin
        bi.req0_valid = 1'b0; bi.req1_valid = 1'b0; bi.rsp_ready = 1'b0;
        bi.req0_key = '0; bi.req0_data = '0; bi.req1_key = '0; bi.req1_data = '0;
        bi.core_result = RES;
        ti.req0_valid = 1'b0; ti.req1_valid = 1'b0; ti.rsp_ready = 1'b0;
        ti.req0_key = '0; ti.req0_data = '0; ti.req1_key = '0; ti.req1_data = '0;
        ti.core_done = 1'b0; ti.core_result = '0;
        test_reset;
        test_round_robin;
        test_single;
        test_hold;
        test_timeout;
        test_coincide;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
